mmio_timer_irq: RTL and testbench

//  Memory-mapped countdown timer: a responder on the CPU memory bus (mem_cmd/mem_addr/write_data/read_data).

---
 rtl/mmio_timer_irq_pkg.sv | 47 ++++
 rtl/mmio_timer_irq_prescaler.sv | 38 +++
 rtl/mmio_timer_irq.sv | 155 +++++++++++++++
 tb/tb_mmio_timer_irq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_timer_irq_pkg.sv
// -----------------------------------------------------------------------------
// mmio_timer_irq_pkg
//   Shared memory-bus definitions for the MMIO peripherals: bus command codes,
//   peripheral base word addresses, timer register offsets and bit positions.
//   Imported by the timer top and its prescaler.
// -----------------------------------------------------------------------------
package mmio_timer_irq_pkg;

   // Memory-bus command codes driven by the CPU; every other value is idle.
   localparam logic [1:0] MIDLE  = 2'b00;
   localparam logic [1:0] MWRITE = 2'b01;
   localparam logic [1:0] MREAD  = 2'b10;

   // Peripheral base word addresses. Each responder owns a 4-word window.
   localparam logic [8:0] LED_BASE   = 9'h100;
   localparam logic [8:0] SW_BASE    = 9'h140;
   localparam logic [8:0] TIMER_BASE = 9'h180;

   // Timer register offsets within the window (mem_addr[1:0]).
   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_RELOAD = 2'd1,
      REG_COUNT  = 2'd2,
      REG_STATUS = 2'd3
   } reg_off_e;

   // CTRL and STATUS bit positions.
   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_AUTO_BIT  = 1;
   localparam int CTRL_IE_BIT    = 2;
   localparam int STATUS_EXP_BIT = 0;
   localparam int STATUS_OVR_BIT = 1;

   // CTRL register image, MSB first so it lines up with write_data[2:0].
   typedef struct packed {
      logic ie;       // interrupt enable
      logic auto_rl;  // reload COUNT from RELOAD on expiry
      logic en;       // timer running
   } ctrl_t;

   // A 4-word window is selected by the upper seven address bits only.
   function automatic logic in_window(input logic [6:0] addr_hi,
                                      input logic [6:0] base_hi);
      return addr_hi == base_hi;
   endfunction

endpackage : mmio_timer_irq_pkg

// File: rtl/mmio_timer_irq_prescaler.sv
// -----------------------------------------------------------------------------
// mmio_timer_irq_prescaler
//   Divides clk down to the timer tick. The phase counter pc runs only while
//   en is high and restarts from zero whenever clr pulses (CTRL write), so the
//   first tick after enabling always lands PRESCALE cycles later.
//   PRESCALE must lie in 1..65535; with PRESCALE=1 every enabled cycle ticks.
// -----------------------------------------------------------------------------
module mmio_timer_irq_prescaler #(
   parameter logic [15:0] PRESCALE = 16'd50000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [15:0] LAST = PRESCALE - 16'd1;

   logic [15:0] pc;

   // tick is decoded from the flop, so it is valid for the whole cycle and a
   // clr in the same cycle does not suppress it, only restarts the phase.
   assign tick = en & (pc == LAST);

   // Phase counter: held at zero while disabled or being cleared, wraps on tick.
   // NOTE: state flops use non-blocking assignments so every always_ff samples
   // the pre-edge values of the others, independent of evaluation order.
   always_ff @(posedge clk) begin
      if (reset || !en || clr)
         pc <= 16'd0;
      else if (pc == LAST)
         pc <= 16'd0;
      else
         pc <= pc + 16'd1;
   end

endmodule : mmio_timer_irq_prescaler

// File: rtl/mmio_timer_irq.sv
// -----------------------------------------------------------------------------
// mmio_timer_irq
//   Memory-mapped countdown timer responding in a 4-word window on the CPU
//   memory bus. Registers:
//     0 CTRL   RW    [0] EN, [1] AUTO, [2] IE
//     1 RELOAD RW    value loaded into COUNT on an auto-reload expiry
//     2 COUNT  RW    live count; a write loads the counter directly
//     3 STATUS W1C   [0] EXP sticky expiry, [1] OVR (optional)
//   Reads are combinational: rd_en/rd_data are valid in the same cycle as the
//   MREAD command, so the surrounding top can drive its tri-state buffer.
//   irq = EXP & IE is a level request that stays up until EXP is cleared or
//   IE is dropped.
//
//   Build option: define MMIO_TIMER_OVERRUN_EN to add the sticky STATUS[1] OVR
//   flag, set on an expiry while EXP is still pending. Without it STATUS[1]
//   reads 0 and no flop is built.
// -----------------------------------------------------------------------------
module mmio_timer_irq
   import mmio_timer_irq_pkg::*;
#(
   parameter logic [8:0]  BASE_ADDR = TIMER_BASE,
   parameter logic [15:0] PRESCALE  = 16'd50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  mem_cmd,
   input  logic [8:0]  mem_addr,
   input  logic [15:0] write_data,
   output logic [15:0] rd_data,
   output logic        rd_en,
   output logic        irq
);

   // ---------------------------------------------------------------- decode
   logic     sel;
   logic     wr_cmd;
   reg_off_e off;
   logic     wr_ctrl;
   logic     wr_reload;
   logic     wr_count;
   logic     wr_status;

   assign sel    = in_window(mem_addr[8:2], BASE_ADDR[8:2]);
   assign off    = reg_off_e'(mem_addr[1:0]);
   assign wr_cmd = sel & (mem_cmd == MWRITE);

   // Reset also blanks the read path so nothing is driven onto the shared bus
   // while the block is being reset.
   assign rd_en  = sel & (mem_cmd == MREAD) & ~reset;

   assign wr_ctrl   = wr_cmd & (off == REG_CTRL);
   assign wr_reload = wr_cmd & (off == REG_RELOAD);
   assign wr_count  = wr_cmd & (off == REG_COUNT);
   assign wr_status = wr_cmd & (off == REG_STATUS);

   // ------------------------------------------------------------- registers
   ctrl_t       ctrl;
   logic [15:0] reload;
   logic [15:0] count;
   logic        exp_flag;
   logic        ovr_rd;
   logic        tick;
   logic        expiry;

   // Tick source; a CTRL write restarts the tick phase.
   mmio_timer_irq_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (ctrl.en),
      .clr   (wr_ctrl),
      .tick  (tick)
   );

   // An expiry is a tick that finds the counter already at zero.
   assign expiry = tick & (count == 16'd0);

   // CTRL: CPU write wins over the one-shot auto-disable on the same edge.
   always_ff @(posedge clk) begin
      if (reset)
         ctrl <= '0;
      else if (wr_ctrl)
         ctrl <= ctrl_t'(write_data[2:0]);
      else if (expiry && !ctrl.auto_rl)
         ctrl.en <= 1'b0;
   end

   // RELOAD: only ever changed by the CPU; sampled at the next expiry.
   always_ff @(posedge clk) begin
      if (reset)
         reload <= 16'd0;
      else if (wr_reload)
         reload <= write_data;
   end

   // COUNT: CPU write beats the tick; otherwise decrement, reload or hold at 0.
   always_ff @(posedge clk) begin
      if (reset)
         count <= 16'd0;
      else if (wr_count)
         count <= write_data;
      else if (tick) begin
         if (count != 16'd0)
            count <= count - 16'd1;
         else if (ctrl.auto_rl)
            count <= reload;
      end
   end

   // EXP: sticky expiry flag; a set on the same edge as a W1C wins.
   always_ff @(posedge clk) begin
      if (reset)
         exp_flag <= 1'b0;
      else
         exp_flag <= expiry | (exp_flag & ~(wr_status & write_data[STATUS_EXP_BIT]));
   end

`ifdef MMIO_TIMER_OVERRUN_EN
   logic ovr_flag;

   // OVR: sticky overrun when an expiry arrives with EXP still pending.
   always_ff @(posedge clk) begin
      if (reset)
         ovr_flag <= 1'b0;
      else
         ovr_flag <= (expiry & exp_flag)
                   | (ovr_flag & ~(wr_status & write_data[STATUS_OVR_BIT]));
   end

   assign ovr_rd = ovr_flag;
`else
   assign ovr_rd = 1'b0;
`endif

   // Level interrupt straight from the flops, no extra register stage.
   assign irq = exp_flag & ctrl.ie;

   // Read mux: selected register while this block owns the bus, else zero.
   // NOTE: every output of an always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      rd_data = 16'h0000;
      if (rd_en) begin
         case (off)
            REG_CTRL:   rd_data = {13'd0, ctrl};
            REG_RELOAD: rd_data = reload;
            REG_COUNT:  rd_data = count;
            REG_STATUS: rd_data = {14'd0, ovr_rd, exp_flag};
            default:    rd_data = 16'h0000;
         endcase
      end
   end

endmodule : mmio_timer_irq

// File: tb/tb_mmio_timer_irq.sv
// -----------------------------------------------------------------------------
// tb_mmio_timer_irq
//   Directed and randomized checks of the MMIO countdown timer with
//   PRESCALE=4 and BASE_ADDR=9'h180. Expected register values for the random
//   runs come from closed-form arithmetic on the tick count since enable.
//   Honours MMIO_TIMER_OVERRUN_EN for the STATUS[1] expectations.
// -----------------------------------------------------------------------------
module tb_mmio_timer_irq;
   import mmio_timer_irq_pkg::*;

   localparam logic [8:0]  BASE = 9'h180;
   localparam logic [15:0] PS   = 16'd4;
   localparam int          P    = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  mem_cmd = MIDLE;
   logic [8:0]  mem_addr = 9'd0;
   logic [15:0] write_data = 16'd0;
   logic [15:0] rd_data;
   logic        rd_en;
   logic        irq;

   int tests = 0;
   int fails = 0;

   mmio_timer_irq #(
      .BASE_ADDR (BASE),
      .PRESCALE  (PS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_cmd    (mem_cmd),
      .mem_addr   (mem_addr),
      .write_data (write_data),
      .rd_data    (rd_data),
      .rd_en      (rd_en),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Hard stop in case a wait escapes its bound.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // All bus tasks start and end 1 time unit after a rising edge.
   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] off, input logic [15:0] d);
      mem_cmd    = MWRITE;
      mem_addr   = BASE + 9'(off);
      write_data = d;
      @(posedge clk);
      #1;
      mem_cmd    = MIDLE;
   endtask

   task automatic bus_read(input logic [8:0] addr, output logic [15:0] d,
                           output logic en, output logic irq_s);
      mem_cmd  = MREAD;
      mem_addr = addr;
      #3;
      d     = rd_data;
      en    = rd_en;
      irq_s = irq;
      @(posedge clk);
      #1;
      mem_cmd  = MIDLE;
   endtask

   task automatic read_check(input string tag, input logic [1:0] off, input logic [15:0] expv);
      logic [15:0] d;
      logic        e;
      logic        q;
      bus_read(BASE + 9'(off), d, e, q);
      check(tag, 32'(d), 32'(expv));
   endtask

   // Disable, clear flags, load RELOAD/COUNT, then start with the given CTRL.
   task automatic start_timer(input logic [15:0] rl, input logic [15:0] c0, input logic [2:0] ctl);
      bus_write(REG_CTRL, 16'h0000);
      bus_write(REG_STATUS, 16'h0003);
      bus_write(REG_RELOAD, rl);
      bus_write(REG_COUNT, c0);
      bus_write(REG_CTRL, {13'd0, ctl});
   endtask

   // Reference model: t = clock edges since the enabling CTRL write edge.
   // Ticks land every P edges; tick k = c0+1 is the first expiry, and with
   // auto-reload every (rl+1) ticks after that.
   function automatic int m_count(int t, int c0, int rl, bit au);
      int k = t / P;
      if (k <= c0) return c0 - k;
      if (!au)     return 0;
      return rl - ((k - (c0 + 1)) % (rl + 1));
   endfunction

   function automatic int m_expiries(int t, int c0, int rl, bit au);
      int k = t / P;
      if (k <= c0) return 0;
      if (!au)     return 1;
      return 1 + (k - (c0 + 1)) / (rl + 1);
   endfunction

   function automatic logic [15:0] m_status(int n);
`ifdef MMIO_TIMER_OVERRUN_EN
      return {14'd0, n >= 2, n >= 1};
`else
      return {15'd0, n >= 1};
`endif
   endfunction

   initial begin
      logic [15:0] d;
      logic        e;
      logic        q;
      int          t;
      int          c0;
      int          rl;
      int          w;
      int          n;
      bit          au;
      bit          ie;
      logic [15:0] ovr_exp;

      // ---------------------------------------------------------- power-on reset
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("por_irq", 32'(irq), 32'd0);
      check("por_rd_en", 32'(rd_en), 32'd0);

      // ---------------------------------------------------------- 1 reset mid-count
      bus_write(REG_COUNT, 16'd100);
      bus_write(REG_CTRL, 16'h0005);
      repeat (7) idle_cycle();
      reset    = 1'b1;
      mem_cmd  = MREAD;
      mem_addr = BASE + 9'd2;
      #3;
      check("rst_hold_rd_en", 32'(rd_en), 32'd0);
      check("rst_hold_rd_data", 32'(rd_data), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      mem_cmd = MIDLE;
      read_check("rst_ctrl", REG_CTRL, 16'h0000);
      read_check("rst_reload", REG_RELOAD, 16'h0000);
      read_check("rst_count", REG_COUNT, 16'h0000);
      read_check("rst_status", REG_STATUS, 16'h0000);
      check("rst_irq", 32'(irq), 32'd0);
      bus_read(SW_BASE, d, e, q);
      check("sw_addr_rd_en", 32'(e), 32'd0);
      check("sw_addr_rd_data", 32'(d), 32'd0);
      bus_read(BASE + 9'd4, d, e, q);
      check("above_window_rd_en", 32'(e), 32'd0);
      bus_read(BASE + 9'd1, d, e, q);
      check("in_window_rd_en", 32'(e), 32'd1);

      // ---------------------------------------------------------- 2 one-shot
      start_timer(16'd0, 16'd3, 3'b101);
      t = 0;
      while (irq !== 1'b1 && t < 64) begin
         idle_cycle();
         t++;
      end
      check("oneshot_irq_latency", 32'(t), 32'd16);
      read_check("oneshot_ctrl", REG_CTRL, 16'h0004);
      read_check("oneshot_count", REG_COUNT, 16'h0000);
      check("oneshot_irq_hold", 32'(irq), 32'd1);

      // ---------------------------------------------------------- 3 auto-reload
      start_timer(16'd2, 16'd0, 3'b111);
      t = 0;
      while (irq !== 1'b1 && t < 64) begin
         idle_cycle();
         t++;
      end
      check("auto_first_expiry", 32'(t), 32'd4);
      bus_write(REG_STATUS, 16'h0001);
      t++;
      check("auto_w1c_drops_irq", 32'(irq), 32'd0);
      while (irq !== 1'b1 && t < 64) begin
         idle_cycle();
         t++;
      end
      check("auto_second_expiry", 32'(t), 32'd16);
      bus_write(REG_STATUS, 16'h0001);
      t++;
      check("auto_w1c_drops_irq2", 32'(irq), 32'd0);

      // ---------------------------------------------------------- 4 W1C on expiry edge
      while (t < 27) begin
         idle_cycle();
         t++;
      end
      bus_write(REG_STATUS, 16'h0001);
      t++;
      check("collide_irq", 32'(irq), 32'd1);
      read_check("collide_status", REG_STATUS, 16'h0001);

      // ---------------------------------------------------------- 5 write priority
      start_timer(16'd0, 16'd8, 3'b001);
      repeat (3) idle_cycle();
      bus_write(REG_COUNT, 16'h0010);
      read_check("count_write_beats_tick", REG_COUNT, 16'h0010);
      bus_write(REG_RELOAD, 16'h1234);
      read_check("reload_keeps_count", REG_COUNT, 16'h0010);
      idle_cycle();
      read_check("count_resumes", REG_COUNT, 16'h000F);
      read_check("reload_value", REG_RELOAD, 16'h1234);

      // ---------------------------------------------------------- one-shot expiry vs CTRL write
      start_timer(16'd0, 16'd0, 3'b101);
      repeat (3) idle_cycle();
      bus_write(REG_CTRL, 16'h0005);
      check("ctrl_vs_oneshot_irq", 32'(irq), 32'd1);
      read_check("ctrl_vs_oneshot_ctrl", REG_CTRL, 16'h0005);

      // ---------------------------------------------------------- 6 overrun
`ifdef MMIO_TIMER_OVERRUN_EN
      ovr_exp = 16'h0003;
`else
      ovr_exp = 16'h0001;
`endif
      start_timer(16'd0, 16'd0, 3'b011);
      repeat (9) idle_cycle();
      read_check("overrun_status", REG_STATUS, ovr_exp);
      check("overrun_no_irq_without_ie", 32'(irq), 32'd0);
      bus_write(REG_CTRL, 16'h0000);
      bus_write(REG_STATUS, 16'h0000);
      read_check("status_write0_noop", REG_STATUS, ovr_exp);
      bus_write(REG_STATUS, 16'h0002);
      read_check("status_w1c_bit1", REG_STATUS, 16'h0001);

      // ---------------------------------------------------------- randomized runs
      for (int i = 0; i < 12; i++) begin
         c0 = int'($urandom_range(0, 5));
         rl = int'($urandom_range(0, 3));
         au = 1'($urandom_range(0, 1));
         ie = 1'($urandom_range(0, 1));
         w  = int'($urandom_range(0, 40));
         start_timer(16'(rl), 16'(c0), {ie, au, 1'b1});
         repeat (w) idle_cycle();
         read_check($sformatf("rnd%0d_count_t%0d", i, w), REG_COUNT,
                    16'(m_count(w, c0, rl, au)));
         n = m_expiries(w + 1, c0, rl, au);
         bus_read(BASE + 9'(REG_STATUS), d, e, q);
         check($sformatf("rnd%0d_status", i), 32'(d), 32'(m_status(n)));
         check($sformatf("rnd%0d_irq", i), 32'(q), 32'(ie && (n >= 1)));
         n = m_expiries(w + 2, c0, rl, au);
         read_check($sformatf("rnd%0d_ctrl", i), REG_CTRL,
                    {13'd0, ie, au, !(!au && n >= 1)});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_mmio_timer_irq
